// File: rtl/seven_segment_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_segment_mux_if : digit/blank inputs and display pin outputs        |
// | Optional brightness input when SEVEN_SEGMENT_BRIGHTNESS_EN is defined.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface seven_segment_mux_if #(
  parameter int NUM_DIGITS = 2
);
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank_mask;
`ifdef SEVEN_SEGMENT_BRIGHTNESS_EN
  logic [3:0]              brightness;
`endif
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   anode;
  logic [c_idx_w-1:0]      digit_idx;
  logic                    frame_tick;

`ifdef SEVEN_SEGMENT_BRIGHTNESS_EN
  modport master (output digits, blank_mask, brightness,
                  input  seg, anode, digit_idx, frame_tick);
  modport slave  (input  digits, blank_mask, brightness,
                  output seg, anode, digit_idx, frame_tick);
`else
  modport master (output digits, blank_mask,
                  input  seg, anode, digit_idx, frame_tick);
  modport slave  (input  digits, blank_mask,
                  output seg, anode, digit_idx, frame_tick);
`endif
endinterface
`default_nettype wire

// File: rtl/seven_segment_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_segment_mux : frame-shadowed, dead-timed multiplexed 7-seg driver  |
// | Optional PWM dimming via macro SEVEN_SEGMENT_BRIGHTNESS_EN.              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module seven_segment_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 24000,
  parameter int DEADTIME    = 480
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  seven_segment_mux_if.slave bus
);
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_cnt_w = $clog2(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_idx_w-1:0]      r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_anode;

  logic                    w_load;
  logic                    w_dead;
  logic                    w_pwm_on;
  logic [4*NUM_DIGITS-1:0] w_digits;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_cur_dig;
  logic                    w_cur_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg_dec;
  logic                    w_lit;

  assign w_load = (r_idx == '0) && (r_cnt == '0);

  // The frame-start cycle already displays the freshly captured values.
  assign w_digits = w_load ? bus.digits     : r_sh_digits;
  assign w_blank  = w_load ? bus.blank_mask : r_sh_blank;

  generate
    if (DEADTIME == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_cnt < c_cnt_w'(DEADTIME));
    end
  endgenerate

`ifdef SEVEN_SEGMENT_BRIGHTNESS_EN
  logic [3:0] r_pwm;
  logic [3:0] r_sh_bright;
  logic [3:0] w_bright;

  assign w_bright = w_load ? bus.brightness : r_sh_bright;
  assign w_pwm_on = (r_pwm < w_bright);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pwm       <= 4'd0;
      r_sh_bright <= 4'd0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (w_load) begin
        r_sh_bright <= bus.brightness;
      end
    end
  end
`else
  assign w_pwm_on = 1'b1;
`endif

  always_comb begin
    w_cur_dig   = 4'h0;
    w_cur_blank = 1'b1;
    w_onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_cur_dig   = w_digits[4*i +: 4];
        w_cur_blank = w_blank[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_cur_dig)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  assign w_lit = !w_dead && !w_cur_blank && w_pwm_on;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sh_digits <= '0;
      r_sh_blank  <= '1;
      r_seg       <= 7'h7F;
      r_anode     <= '1;
    end else begin
      if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) begin
        r_sh_digits <= bus.digits;
        r_sh_blank  <= bus.blank_mask;
      end
      r_seg   <= w_lit ? w_seg_dec : 7'h7F;
      r_anode <= w_lit ? ~w_onehot : '1;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.anode      = r_anode;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_tick = (r_idx == c_idx_last) && (r_cnt == c_cnt_last);

endmodule
`default_nettype wire
